// File: rtl/seq_computer_pkg.sv
// rtl/seq_computer_pkg.sv - opcodes, instruction fields and FSM states for seq_computer
package seq_computer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 8;
  // Bits above this are never decoded, so memory only keeps the low part.
  localparam int INSTR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd14);
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational ALU for seq_computer
module seq_alu
  import seq_computer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [4:0] amt;

  always_comb begin
    amt    = 5'(32'(b[4:0]) % WIDTH);
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << amt;
      OP_SHR:  result = a >> amt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_computer.sv
// rtl/seq_computer.sv - loadable-program sequential computer with fetch/exec FSM
module seq_computer
  import seq_computer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       instruction,
  input  logic              start,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]    regs [4];

  logic [3:0]          op;
  logic [1:0]          rd, rs1, rs2;
  logic [WIDTH-1:0]    alu_result;
  logic                illegal, stop;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^instruction[31:INSTR_W];

  assign op  = ir[OPC_LSB +: 4];
  assign rd  = ir[RD_LSB +: 2];
  assign rs1 = ir[RS1_LSB +: 2];
  assign rs2 = ir[RS2_LSB +: 2];

  // The last word ends the run even without HALT; the PC never wraps.
  assign illegal = op_is_illegal(op);
  assign stop    = illegal || (op == OP_HALT) || (pc == ADDR_W'(DEPTH - 1));
  assign busy    = (state != ST_IDLE);

  seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (regs[rs1]),
    .b      (regs[rs2]),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = stop ? ST_IDLE : ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ir        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++)     regs[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i]  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A load on the start edge lands before the first fetch reads memory.
          if (load_en) mem[address] <= instruction[INSTR_W-1:0];
          if (start) begin
            pc      <= '0;
            regs[0] <= x;
            regs[1] <= y;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        ST_FETCH: ir <= mem[pc];
        ST_EXEC: begin
          if (op_writes_reg(op)) regs[rd] <= alu_result;
          if (op == OP_OUT) begin
            out       <= regs[rs1];
            out_valid <= 1'b1;
          end
          if (stop) begin
            done <= 1'b1;
            err  <= illegal;
          end else begin
            pc <= pc + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_computer.sv
// tb/tb_seq_computer.sv - table-driven and scoreboard bench for seq_computer
module tb_seq_computer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [2:0]  address;
  logic [31:0] instruction;
  logic        start;
  logic [31:0] x, y;
  logic [31:0] out;
  logic        out_valid, busy, done, err;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;

  seq_computer dut (
    .clk(clk), .reset(reset), .load_en(load_en), .address(address),
    .instruction(instruction), .start(start), .x(x), .y(y),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid got=%h expected=none", out);
      end else begin
        exp_val = exp_q.pop_front();
        check("scoreboard_out", out, exp_val);
      end
    end
  end

  task automatic load_word(input logic [2:0] a, input logic [31:0] w);
    @(negedge clk);
    load_en = 1'b1; address = a; instruction = w;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_prog3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    load_word(3'd0, w0);
    load_word(3'd1, w1);
    load_word(3'd2, w2);
  endtask

  task automatic kick(input logic [31:0] xa, input logic [31:0] ya);
    @(negedge clk);
    x = xa; y = ya; start = 1'b1; pulses = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] xa;
    logic [31:0] ya;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[$];
  int   n;

  initial begin
    reset = 1'b0; load_en = 1'b0; address = '0; instruction = '0;
    start = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("rst_out", out, 32'd0);
    check("rst_flags", {28'd0, out_valid, busy, done, err}, 32'd0);
    reset = 1'b1;

    vecs.push_back('{4'd1, 32'd3,          32'd4,          32'd7});
    vecs.push_back('{4'd2, 32'd16,         32'd5,          32'd11});
    vecs.push_back('{4'd2, 32'd5,          32'd16,         32'hFFFF_FFF5});
    vecs.push_back('{4'd1, 32'hFFFF_FFFF,  32'd1,          32'd0});
    vecs.push_back('{4'd3, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000});
    vecs.push_back('{4'd4, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF});
    vecs.push_back('{4'd5, 32'h0000_FF00,  32'h0000_0FF0,  32'h0000_F0F0});
    vecs.push_back('{4'd6, 32'd1,          32'd31,         32'h8000_0000});
    vecs.push_back('{4'd7, 32'h8000_0000,  32'd4,          32'h0800_0000});
    vecs.push_back('{4'd6, 32'd3,          32'h21,         32'd6});
    vecs.push_back('{4'd7, 32'h0000_00F0,  32'h24,         32'h0000_000F});

    // R2 = R0 op R1; OUT R2; HALT
    foreach (vecs[i]) begin
      load_prog3(32'h120 | 32'(vecs[i].op), 32'h088, 32'h00F);
      exp_q.push_back(vecs[i].want);
      kick(vecs[i].xa, vecs[i].ya);
      check("busy_running", 32'(busy), 32'd1);
      wait_done(n);
      check("done_cycles", n, 6);
      check("err_clear", 32'(err), 32'd0);
      check("pulse_count", pulses, 1);
    end

    // rd == rs1 == rs2: R0 = R0 + R0 reads the old R0
    load_prog3(32'h001, 32'h008, 32'h00F);
    exp_q.push_back(32'd10);
    kick(32'd5, 32'd0);
    wait_done(n);
    check("self_add_pulses", pulses, 1);

    // Eight NOPs, no HALT: implicit halt at the last address
    for (int a = 0; a < 8; a++) load_word(3'(a), 32'h0);
    kick(32'd1, 32'd2);
    wait_done(n);
    check("nop_cycles", n, 16);
    check("nop_pc", 32'(dut.pc), 32'd7);
    check("nop_pulses", pulses, 0);
    check("nop_out_held", out, 32'd10);

    // Illegal opcode with rd=R0: no writeback, err and done set
    load_word(3'd0, 32'h009);
    kick(32'h55, 32'h66);
    wait_done(n);
    check("ill_cycles", n, 2);
    check("ill_err", 32'(err), 32'd1);
    check("ill_r0", dut.regs[0], 32'h55);
    load_word(3'd0, 32'h00F);
    kick(32'd0, 32'd0);
    check("ill_err_cleared", 32'(err), 32'd0);
    wait_done(n);
    check("halt_cycles", n, 2);

    // Load and start during busy are ignored
    load_prog3(32'h121, 32'h088, 32'h00F);
    exp_q.push_back(32'd7);
    kick(32'd3, 32'd4);
    load_en = 1'b1; address = 3'd1; instruction = 32'h00F;
    @(negedge clk);
    load_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_cycles", n + 2, 6);
    check("busy_pulses", pulses, 1);
    check("busy_mem1", 32'(dut.mem[1]), 32'h088);

    // Load together with start: execution sees the new word 0 (HALT)
    @(negedge clk);
    load_en = 1'b1; address = 3'd0; instruction = 32'h00F;
    x = 32'd3; y = 32'd4; start = 1'b1; pulses = 0;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    wait_done(n);
    check("ldstart_cycles", n, 2);
    check("ldstart_pulses", pulses, 0);

    // Reset during the OUT EXEC cycle, then restart without reload
    load_prog3(32'h121, 32'h088, 32'h00F);
    kick(32'd3, 32'd4);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_out", out, 32'd0);
    check("mid_reset_flags", {28'd0, out_valid, busy, done, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    kick(32'd3, 32'd4);
    wait_done(n);
    check("post_reset_cycles", n, 16);
    check("post_reset_out", out, 32'd0);
    check("post_reset_pulses", pulses, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
